// File: rtl/midi_decoder_if.sv
// Byte-stream in / note-event out bundle for the MIDI receive decoder.
// The decoder sits on the slave side; the byte source and event consumer use master.
interface midi_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       event_valid;
  logic       event_note_on;
  logic [3:0] event_channel;
  logic [6:0] event_midi_note;
  logic [6:0] event_velocity;
  logic [3:0] event_note;
  logic [1:0] event_octave;
  logic       event_in_range;

  modport master (
    output byte_in, byte_valid,
    input  event_valid, event_note_on, event_channel, event_midi_note,
           event_velocity, event_note, event_octave, event_in_range
  );

  modport slave (
    input  byte_in, byte_valid,
    output event_valid, event_note_on, event_channel, event_midi_note,
           event_velocity, event_note, event_octave, event_in_range
  );
endinterface

// File: rtl/midi_decoder.sv
// MIDI byte-stream parser emitting registered note-on/note-off events.
// Supports running status, real-time interleaving and SysEx/system-common skipping.
module midi_decoder #(
  parameter logic [15:0] CHANNEL_MASK   = 16'hFFFF,
  parameter logic [6:0]  MIDI_NOTE_BASE = 7'h00
) (
  input logic          clk,
  input logic          reset,
  midi_decoder_if.slave bus
);

  typedef enum logic [2:0] {NO_STATUS, WAIT_D1, WAIT_D2, SYSEX, SKIP} state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic       complete;
  logic       emit;

  logic       ev_valid_q, ev_on_q, ev_inr_q;
  logic [3:0] ev_ch_q, ev_note_q;
  logic [6:0] ev_mnote_q, ev_vel_q;
  logic [1:0] ev_oct_q;

  logic [7:0] off;
  logic       in_range;
  logic [3:0] note_d;
  logic [1:0] oct_d;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    complete = 1'b0;
    if (bus.byte_valid && (bus.byte_in < 8'hF8)) begin
      if (bus.byte_in[7]) begin
        if (bus.byte_in < 8'hF0) begin
          status_d = bus.byte_in;
          state_d  = WAIT_D1;
        end else begin
          status_d = 8'h00;
          if (bus.byte_in == 8'hF0)      state_d = SYSEX;
          else if (bus.byte_in == 8'hF7) state_d = NO_STATUS;
          else                           state_d = SKIP;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            // Program change and channel pressure carry a single data byte
            if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) begin
              complete = 1'b1;
            end else begin
              d1_d    = bus.byte_in[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            complete = 1'b1;
            state_d  = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign emit = complete && (status_q[7:5] == 3'b100) && CHANNEL_MASK[status_q[3:0]];

  // Offset split by compare/subtract; the low nibble wraps so 4-bit subtraction suffices
  always_comb begin
    off      = {1'b0, d1_q} - {1'b0, MIDI_NOTE_BASE};
    in_range = !off[7] && (off <= 8'd47);
    note_d   = 4'd0;
    oct_d    = 2'd0;
    if (in_range) begin
      if (off >= 8'd36) begin
        oct_d  = 2'd3;
        note_d = off[3:0] - 4'd4;
      end else if (off >= 8'd24) begin
        oct_d  = 2'd2;
        note_d = off[3:0] - 4'd8;
      end else if (off >= 8'd12) begin
        oct_d  = 2'd1;
        note_d = off[3:0] - 4'd12;
      end else begin
        note_d = off[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= NO_STATUS;
      status_q   <= 8'h00;
      d1_q       <= 7'h00;
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_ch_q    <= 4'h0;
      ev_mnote_q <= 7'h00;
      ev_vel_q   <= 7'h00;
      ev_note_q  <= 4'h0;
      ev_oct_q   <= 2'd0;
      ev_inr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      d1_q       <= d1_d;
      ev_valid_q <= emit;
      if (emit) begin
        ev_on_q    <= status_q[4] && (bus.byte_in[6:0] != 7'h00);
        ev_ch_q    <= status_q[3:0];
        ev_mnote_q <= d1_q;
        ev_vel_q   <= bus.byte_in[6:0];
        ev_note_q  <= note_d;
        ev_oct_q   <= oct_d;
        ev_inr_q   <= in_range;
      end
    end
  end

  assign bus.event_valid     = ev_valid_q;
  assign bus.event_note_on   = ev_on_q;
  assign bus.event_channel   = ev_ch_q;
  assign bus.event_midi_note = ev_mnote_q;
  assign bus.event_velocity  = ev_vel_q;
  assign bus.event_note      = ev_note_q;
  assign bus.event_octave    = ev_oct_q;
  assign bus.event_in_range  = ev_inr_q;

endmodule

// File: doc/midi_decoder.md
Name: midi_decoder

Overview:
- Parses a raw MIDI byte stream, one byte per valid strobe, into note-on and note-off events for the voice/demo logic.
- It is the receive-side counterpart of the 24-bit note-message encoder.
- Handles running status, real-time interleaving, SysEx skipping, and velocity-0 note-off.
- Output is a single-cycle event strobe carrying the channel, the raw note, velocity, and a note/octave split relative to MIDI_NOTE_BASE.

Parameters:
- CHANNEL_MASK, 16'hFFFF, bit n = 1 enables events on MIDI channel n; masked channels are parsed but not emitted.
- MIDI_NOTE_BASE, 7'h00, MIDI note that maps to note 0 / octave 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- byte_in  in  8  received MIDI byte.
- byte_valid  in  1  byte_in valid this cycle. No backpressure; a byte is accepted every cycle this is high.
- event_valid  out  1  single-cycle strobe: a note event is presented.
- event_note_on  out  1  1 = note-on, 0 = note-off.
- event_channel  out  4  MIDI channel 0-15.
- event_midi_note  out  7  raw MIDI note number.
- event_velocity  out  7  velocity as received.
- event_note  out  4  (midi_note - MIDI_NOTE_BASE) mod 12, range 0-11.
- event_octave  out  2  (midi_note - MIDI_NOTE_BASE) / 12, range 0-3.
- event_in_range  out  1  MIDI_NOTE_BASE <= midi_note <= MIDI_NOTE_BASE+47; event_note/event_octave are 0 when this is low.

Behaviour:
- Reset: all outputs 0, FSM to NO_STATUS, running status cleared, any partial message discarded. Applies asynchronously at any point, including mid-message.
- Byte classes:
  - data: bit7 = 0.
  - channel status: 0x80-0xEF.
  - SysEx start: 0xF0.
  - system common: 0xF1-0xF7.
  - real-time: 0xF8-0xFF.
- Real-time bytes are ignored entirely in every state: no change to state, running status, or captured bytes.
- FSM states: NO_STATUS, WAIT_D1, WAIT_D2, SYSEX, SKIP.
- Channel status byte, accepted in any state: latch it as running status and abort any partial message.
  - 0x8n, 0x9n, 0xAn, 0xBn, 0xEn are 2-data-byte messages; 0xCn, 0xDn are 1-data-byte messages.
  - Next state is WAIT_D1.
- 0xF0: clear running status, go to SYSEX.
- In SYSEX, data bytes are discarded.
  - 0xF7 goes to NO_STATUS.
  - Any other non-real-time status byte exits SYSEX and is processed normally in the same cycle.
- 0xF1-0xF6: clear running status, go to SKIP. 0xF7 outside SYSEX: clear running status, go to NO_STATUS.
- In SKIP and NO_STATUS, data bytes are discarded.
- WAIT_D1 + data byte:
  - 1-byte message: message complete; return to WAIT_D1 (running status kept).
  - Otherwise capture d1 and go to WAIT_D2.
- WAIT_D2 + data byte: capture d2; message complete; return to WAIT_D1 for running status.
- Emit rule: on completion of a 0x8n or 0x9n message with CHANNEL_MASK[n] = 1, event_valid is high for exactly one cycle, on the clock edge after the final data byte (latency 1). Event fields are registered and held until the next event.
  - 0x8n: note-on = 0, velocity = d2.
  - 0x9n with d2 = 0: note-on = 0, velocity = 0.
  - 0x9n with d2 != 0: note-on = 1.
  - All other channel messages and masked channels complete silently.
- Back-to-back messages can complete on consecutive bytes, so event_valid may be high on consecutive cycles.
- Arithmetic: the offset is 8-bit midi_note - MIDI_NOTE_BASE. Out of range when the result is negative or greater than 47. The /12 and mod 12 split must be computed without a general divider (compare/subtract chain or a 48-entry table).

Test Plan:
- Stream 0x93, 0x3C, 0x64 with base 0x00 -> one event_valid pulse 1 cycle after 0x64: note_on = 1, channel = 3, midi_note = 60, velocity = 100, in_range = 0 (60 > 47).
- Base 0x30; stream 0x90, 0x34, 0x7F, 0x36, 0x00 (running status) -> two events:
  - note-on, note 4, octave 0, in_range = 1, velocity = 127.
  - note-off, note 6, velocity 0.
- Stream 0x80, 0x40, 0xF8, 0x20 -> a single note-off event (note 0x40, velocity 0x20); the interleaved 0xF8 has no effect.
- Stream 0xF0, 0x12, 0x34, 0xF7, 0x45, 0x50 -> no events; data after 0xF7 is dropped because running status was cleared.
- CHANNEL_MASK = 16'hFFFE; stream 0x90, 0x3C, 0x40, 0xC1, 0x05, 0x91, 0x3C, 0x40 -> exactly one event, on channel 1; channel 0 and the program change produce nothing.
- Stream 0x90, 0x3C, assert reset, release, then 0x40 -> no event; a following 0x90, 0x3C, 0x40 yields one event.
